// File: rtl/wb_regbank_pkg.sv
// Shared types and helpers for the register bank with sub-window master.
// Holds the window FSM encoding, byte-lane mask expansion and counter sizing.
package wb_regbank_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SUB_WR = 2'd1,
      SUB_RD = 2'd2,
      RESP   = 2'd3
   } win_state_t;

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{sel[i]}};
      end
      return m;
   endfunction

   function automatic int cnt_width(input int limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/wb_regbank_subwin_master.sv
// Window master: runs one downstream Wishbone cycle, bounded by a timeout.
// Completion is reported combinationally in the cycle the response (or expiry) occurs.
module wb_subwin_master
   import wb_regbank_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              start_we,
   input  logic [ADDR_W-2:0] start_adr,
   input  logic [3:0]        start_sel,
   input  logic [31:0]       start_dat,
   output logic              idle,
   output logic              done,
   output logic              done_err,
   output logic              done_we,
   output logic              sub_cyc,
   output logic              sub_stb,
   output logic              sub_we,
   output logic [ADDR_W-2:0] sub_adr,
   output logic [3:0]        sub_sel,
   output logic [31:0]       sub_wdat,
   input  logic              sub_ack,
   input  logic              sub_err
);

   localparam int TW = cnt_width(TIMEOUT);

   win_state_t    state;
   logic [TW-1:0] cnt;
   logic          in_sub;
   logic          expired;

   assign in_sub   = (state == SUB_WR) || (state == SUB_RD);
   assign expired  = (cnt == TW'(TIMEOUT - 1));
   assign idle     = (state == IDLE);
   // err beats ack, ack beats expiry
   assign done     = in_sub & (sub_ack | sub_err | expired);
   assign done_err = in_sub & (sub_err | (~sub_ack & expired));
   assign done_we  = (state == SUB_WR);
   assign sub_cyc  = in_sub;
   assign sub_stb  = in_sub;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         sub_we   <= 1'b0;
         sub_adr  <= '0;
         sub_sel  <= '0;
         sub_wdat <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= start_we ? SUB_WR : SUB_RD;
                  cnt      <= '0;
                  sub_we   <= start_we;
                  sub_adr  <= start_adr;
                  sub_sel  <= start_sel;
                  sub_wdat <= start_dat;
               end
            end
            SUB_WR, SUB_RD: begin
               if (done) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/wb_regbank_subwin.sv
// Wishbone slave: NUM_REGS byte-maskable control registers plus a forwarding
// window to a downstream block, with optional write-input and read-output stages.
module wb_regbank_subwin
   import wb_regbank_pkg::*;
#(
   parameter int          NUM_REGS    = 4,
   parameter int          ADDR_W      = 8,
   parameter int          WR_IN_PIPE  = 1,
   parameter int          RD_OUT_PIPE = 1,
   parameter int          TIMEOUT     = 255,
   parameter logic [31:0] RESET_VAL   = 32'h0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     wb_cyc_i,
   input  logic                     wb_stb_i,
   input  logic                     wb_we_i,
   input  logic [ADDR_W-1:2]        wb_adr_i,
   input  logic [3:0]               wb_sel_i,
   input  logic [31:0]              wb_dat_i,
   output logic                     wb_ack_o,
   output logic                     wb_err_o,
   output logic                     wb_rty_o,
   output logic                     wb_stall_o,
   output logic [31:0]              wb_dat_o,
   output logic [32*NUM_REGS-1:0]   regs_o,
   output logic                     sub_cyc_o,
   output logic                     sub_stb_o,
   output logic                     sub_we_o,
   output logic [ADDR_W-2:0]        sub_adr_o,
   output logic [3:0]               sub_sel_o,
   output logic [31:0]              sub_dat_o,
   input  logic                     sub_ack_i,
   input  logic                     sub_err_i,
   input  logic [31:0]              sub_dat_i
);

   localparam int IW = ADDR_W - 3;

   logic [31:0]       regs [NUM_REGS];
   logic [31:0]       rd_word;
   logic              busy, req, wr_req, rd_req;
   logic              vld_p0, vld_p1;
   logic              wr_go;
   logic [ADDR_W-1:2] wr_adr;
   logic [3:0]        wr_sel;
   logic [31:0]       wr_dat;
   logic              reg_wr, reg_rd, sub_wr, sub_rd;
   logic              sub_idle, sub_done, sub_done_err, sub_done_we;
   logic              drop_q, sub_rsp;
   logic              wr_rsp_vld, wr_rsp_err;
   logic              rd_rsp_vld, rd_rsp_err;
   logic [31:0]       rd_rsp_dat;
   logic              rd_out_vld, rd_out_err;
   logic [31:0]       rd_out_dat;

   assign busy       = vld_p0 | vld_p1 | wb_ack_o | wb_err_o | ~sub_idle;
   assign req        = wb_cyc_i & wb_stb_i & ~busy;
   assign wr_req     = req & wb_we_i;
   assign rd_req     = req & ~wb_we_i;
   assign wb_stall_o = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);
   assign wb_rty_o   = 1'b0;

   // p0: optional write request stage
   generate
      if (WR_IN_PIPE != 0) begin : g_wr_pipe
         logic [ADDR_W-1:2] adr_p0;
         logic [3:0]        sel_p0;
         logic [31:0]       dat_p0;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) vld_p0 <= 1'b0;
            else       vld_p0 <= wr_req;
         end
         always_ff @(posedge clk_i) begin
            if (wr_req) begin
               adr_p0 <= wb_adr_i;
               sel_p0 <= wb_sel_i;
               dat_p0 <= wb_dat_i;
            end
         end
         assign wr_go  = vld_p0;
         assign wr_adr = adr_p0;
         assign wr_sel = sel_p0;
         assign wr_dat = dat_p0;
      end else begin : g_wr_direct
         assign vld_p0 = 1'b0;
         assign wr_go  = wr_req;
         assign wr_adr = wb_adr_i;
         assign wr_sel = wb_sel_i;
         assign wr_dat = wb_dat_i;
      end
   endgenerate

   assign reg_wr = wr_go & ~wr_adr[ADDR_W-1];
   assign sub_wr = wr_go &  wr_adr[ADDR_W-1];
   assign reg_rd = rd_req & ~wb_adr_i[ADDR_W-1];
   assign sub_rd = rd_req &  wb_adr_i[ADDR_W-1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_REGS; k++) regs[k] <= RESET_VAL;
      end else if (reg_wr) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_adr[ADDR_W-2:2] == IW'(k))
               regs[k] <= (regs[k] & ~lane_mask(wr_sel)) | (wr_dat & lane_mask(wr_sel));
         end
      end
   end

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (wb_adr_i[ADDR_W-2:2] == IW'(k)) rd_word = regs[k];
      end
   end

   generate
      for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
         assign regs_o[32*g +: 32] = regs[g];
      end
   endgenerate

   wb_subwin_master #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) u_sub (
      .clk       (clk_i),
      .rst       (rst_i),
      .start     (sub_wr | sub_rd),
      .start_we  (sub_wr),
      .start_adr (sub_wr ? {wr_adr[ADDR_W-2:2], 2'b00} : {wb_adr_i[ADDR_W-2:2], 2'b00}),
      .start_sel (sub_wr ? wr_sel : wb_sel_i),
      .start_dat (wr_dat),
      .idle      (sub_idle),
      .done      (sub_done),
      .done_err  (sub_done_err),
      .done_we   (sub_done_we),
      .sub_cyc   (sub_cyc_o),
      .sub_stb   (sub_stb_o),
      .sub_we    (sub_we_o),
      .sub_adr   (sub_adr_o),
      .sub_sel   (sub_sel_o),
      .sub_wdat  (sub_dat_o),
      .sub_ack   (sub_ack_i),
      .sub_err   (sub_err_i)
   );

   // Remember a master abort so the eventual window response is swallowed.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)         drop_q <= 1'b0;
      else if (sub_idle) drop_q <= 1'b0;
      else if (!wb_cyc_i) drop_q <= 1'b1;
   end

   assign sub_rsp    = sub_done & ~drop_q & wb_cyc_i;
   assign wr_rsp_vld = reg_wr | (sub_rsp & sub_done_we);
   assign wr_rsp_err = sub_rsp & sub_done_we & sub_done_err;
   assign rd_rsp_vld = reg_rd | (sub_rsp & ~sub_done_we);
   assign rd_rsp_err = sub_rsp & ~sub_done_we & sub_done_err;
   assign rd_rsp_dat = reg_rd ? rd_word : (sub_done_err ? 32'h0 : sub_dat_i);

   // p1: optional read response stage
   generate
      if (RD_OUT_PIPE != 0) begin : g_rd_pipe
         logic        err_p1;
         logic [31:0] dat_p1;
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               vld_p1 <= 1'b0;
               err_p1 <= 1'b0;
            end else begin
               vld_p1 <= rd_rsp_vld;
               err_p1 <= rd_rsp_err;
            end
         end
         always_ff @(posedge clk_i) begin
            if (rd_rsp_vld) dat_p1 <= rd_rsp_dat;
         end
         assign rd_out_vld = vld_p1;
         assign rd_out_err = err_p1;
         assign rd_out_dat = dat_p1;
      end else begin : g_rd_direct
         assign vld_p1     = 1'b0;
         assign rd_out_vld = rd_rsp_vld;
         assign rd_out_err = rd_rsp_err;
         assign rd_out_dat = rd_rsp_dat;
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
      end else begin
         wb_ack_o <= (wr_rsp_vld & ~wr_rsp_err) | (rd_out_vld & ~rd_out_err);
         wb_err_o <= wr_rsp_err | (rd_out_vld & rd_out_err);
         wb_dat_o <= (rd_out_vld & ~rd_out_err) ? rd_out_dat : 32'h0;
      end
   end

endmodule

// File: tb/tb_wb_regbank_subwin.sv
// Directed bench for wb_regbank_subwin: register bank, window forwarding,
// timeout and reset behaviour with both pipeline stages enabled.
module tb_wb_regbank_subwin;

   localparam logic [31:0] RV = 32'hA5A5_0000;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         wb_cyc_i, wb_stb_i, wb_we_i;
   logic [7:2]   wb_adr_i;
   logic [3:0]   wb_sel_i;
   logic [31:0]  wb_dat_i;
   logic         wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o;
   logic [31:0]  wb_dat_o;
   logic [127:0] regs_o;
   logic         sub_cyc_o, sub_stb_o, sub_we_o;
   logic [6:0]   sub_adr_o;
   logic [3:0]   sub_sel_o;
   logic [31:0]  sub_dat_o;
   logic         sub_ack_i, sub_err_i;
   logic [31:0]  sub_dat_i;

   int           n_vec = 0;
   int           n_fail = 0;

   // window responder controls (written only by the stimulus thread)
   int           resp_mode = 0;
   int           resp_delay = 0;
   logic [31:0]  resp_dat = 32'h0;
   logic         force_ack = 1'b0;
   // responder observations (written only by the responder)
   int           sub_cnt = 0;
   int           sub_last = 0;
   logic [6:0]   sub_adr_seen = '0;
   logic         sub_we_seen = 1'b0;
   logic [3:0]   sub_sel_seen = '0;
   logic [31:0]  sub_wdat_seen = '0;

   always #5 clk_i = ~clk_i;

   wb_regbank_subwin #(
      .NUM_REGS    (4),
      .ADDR_W      (8),
      .WR_IN_PIPE  (1),
      .RD_OUT_PIPE (1),
      .TIMEOUT     (8),
      .RESET_VAL   (RV)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wb_cyc_i   (wb_cyc_i),
      .wb_stb_i   (wb_stb_i),
      .wb_we_i    (wb_we_i),
      .wb_adr_i   (wb_adr_i),
      .wb_sel_i   (wb_sel_i),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_o   (wb_ack_o),
      .wb_err_o   (wb_err_o),
      .wb_rty_o   (wb_rty_o),
      .wb_stall_o (wb_stall_o),
      .wb_dat_o   (wb_dat_o),
      .regs_o     (regs_o),
      .sub_cyc_o  (sub_cyc_o),
      .sub_stb_o  (sub_stb_o),
      .sub_we_o   (sub_we_o),
      .sub_adr_o  (sub_adr_o),
      .sub_sel_o  (sub_sel_o),
      .sub_dat_o  (sub_dat_o),
      .sub_ack_i  (sub_ack_i),
      .sub_err_i  (sub_err_i),
      .sub_dat_i  (sub_dat_i)
   );

   // Downstream responder: answers on the resp_delay-th cycle of sub_cyc_o.
   always @(negedge clk_i) begin
      sub_ack_i = force_ack;
      sub_err_i = 1'b0;
      sub_dat_i = resp_dat;
      if (sub_cyc_o) begin
         sub_cnt       = sub_cnt + 1;
         sub_adr_seen  = sub_adr_o;
         sub_we_seen   = sub_we_o;
         sub_sel_seen  = sub_sel_o;
         sub_wdat_seen = sub_dat_o;
         if (resp_mode == 1 && sub_cnt == resp_delay) sub_ack_i = 1'b1;
         if (resp_mode == 2 && sub_cnt == resp_delay) sub_err_i = 1'b1;
      end else begin
         if (sub_cnt != 0) sub_last = sub_cnt;
         sub_cnt = 0;
      end
   end

   task automatic wb_xfer(input logic we, input logic [7:0] badr, input logic [3:0] sel,
                          input logic [31:0] dat, output int lat, output logic was_err,
                          output logic [31:0] rdata, output logic [127:0] regs_at,
                          output int extra);
      logic seen;
      @(negedge clk_i);
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      wb_we_i  = we;
      wb_adr_i = badr[7:2];
      wb_sel_i = sel;
      wb_dat_i = dat;
      lat = -1; was_err = 1'b0; rdata = '0; regs_at = '0; extra = 0; seen = 1'b0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk_i);
         if (wb_ack_o || wb_err_o) begin
            seen    = 1'b1;
            lat     = i;
            was_err = wb_err_o;
            rdata   = wb_dat_o;
            regs_at = regs_o;
         end
      end
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         if (wb_ack_o || wb_err_o) extra++;
      end
   endtask

   task automatic test_reset();
      int lat, extra;
      logic err;
      logic [31:0] rd;
      logic [127:0] ra;
      n_vec++;
      if ({wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, sub_cyc_o, sub_stb_o, sub_we_o} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got %b want 0000000",
                  {wb_ack_o, wb_err_o, wb_rty_o, wb_stall_o, sub_cyc_o, sub_stb_o, sub_we_o});
      end
      n_vec++;
      if ({wb_dat_o, sub_adr_o, sub_sel_o, sub_dat_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h want 0", {wb_dat_o, sub_adr_o, sub_sel_o, sub_dat_o});
      end
      n_vec++;
      if (regs_o !== {4{RV}}) begin
         n_fail++;
         $display("FAIL reset_regs: got %h want %h", regs_o, {4{RV}});
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wb_xfer(1'b0, 8'(4 * k), 4'hF, 32'h0, lat, err, rd, ra, extra);
         n_vec++;
         if (rd !== RV || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read%0d: got %h err=%b want %h err=0", k, rd, err, RV);
         end
         n_vec++;
         if (lat !== 2 || extra !== 0) begin
            n_fail++;
            $display("FAIL reset_read_lat%0d: got lat=%0d extra=%0d want lat=2 extra=0", k, lat, extra);
         end
      end
   endtask

   task automatic test_reg_rw();
      int lat, extra;
      logic err;
      logic [31:0] rd;
      logic [127:0] ra;
      wb_xfer(1'b1, 8'h08, 4'hF, 32'h0, lat, err, rd, ra, extra);
      wb_xfer(1'b1, 8'h08, 4'b0101, 32'h1122_3344, lat, err, rd, ra, extra);
      n_vec++;
      if (lat !== 2 || err !== 1'b0 || extra !== 0) begin
         n_fail++;
         $display("FAIL masked_wr_ack: got lat=%0d err=%b extra=%0d want 2/0/0", lat, err, extra);
      end
      n_vec++;
      if (ra[95:64] !== 32'h0022_0044) begin
         n_fail++;
         $display("FAIL masked_wr_at_ack: got %h want 00220044", ra[95:64]);
      end
      wb_xfer(1'b1, 8'h00, 4'b1010, 32'hCAFE_F00D, lat, err, rd, ra, extra);
      n_vec++;
      if (regs_o !== {RV, 32'h0022_0044, RV, 32'hCAA5_F000}) begin
         n_fail++;
         $display("FAIL regs_after_wr: got %h want %h", regs_o, {RV, 32'h0022_0044, RV, 32'hCAA5_F000});
      end
      wb_xfer(1'b0, 8'h08, 4'hF, 32'h0, lat, err, rd, ra, extra);
      n_vec++;
      if (rd !== 32'h0022_0044 || lat !== 2) begin
         n_fail++;
         $display("FAIL readback_reg2: got %h lat=%0d want 00220044 lat=2", rd, lat);
      end
   endtask

   task automatic test_out_of_range();
      int lat, extra;
      logic err;
      logic [31:0] rd;
      logic [127:0] ra;
      logic [127:0] save;
      save = regs_o;
      wb_xfer(1'b1, 8'h14, 4'hF, 32'hFFFF_FFFF, lat, err, rd, ra, extra);
      n_vec++;
      if (lat !== 2 || err !== 1'b0 || regs_o !== save) begin
         n_fail++;
         $display("FAIL oor_write: got lat=%0d err=%b regs=%h want lat=2 err=0 regs=%h", lat, err, regs_o, save);
      end
      wb_xfer(1'b0, 8'h14, 4'hF, 32'h0, lat, err, rd, ra, extra);
      n_vec++;
      if (lat !== 2 || err !== 1'b0 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL oor_read5: got lat=%0d err=%b data=%h want 2/0/0", lat, err, rd);
      end
      wb_xfer(1'b0, 8'h1C, 4'hF, 32'h0, lat, err, rd, ra, extra);
      n_vec++;
      if (rd !== 32'h0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_read7: got data=%h err=%b want 0/0", rd, err);
      end
   endtask

   task automatic test_sub_read();
      int lat, extra;
      logic err;
      logic [31:0] rd;
      logic [127:0] ra;
      resp_mode = 1; resp_delay = 3; resp_dat = 32'hDEAD_BEEF;
      wb_xfer(1'b0, 8'h90, 4'b0110, 32'h0, lat, err, rd, ra, extra);
      n_vec++;
      if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_read_data: got %h err=%b want deadbeef err=0", rd, err);
      end
      n_vec++;
      if (lat !== 5 || extra !== 0 || sub_last !== 3) begin
         n_fail++;
         $display("FAIL sub_read_timing: got lat=%0d extra=%0d burst=%0d want 5/0/3", lat, extra, sub_last);
      end
      n_vec++;
      if (sub_adr_seen !== 7'h10 || sub_we_seen !== 1'b0 || sub_sel_seen !== 4'b0110) begin
         n_fail++;
         $display("FAIL sub_read_fwd: got adr=%h we=%b sel=%b want 10/0/0110",
                  sub_adr_seen, sub_we_seen, sub_sel_seen);
      end
   endtask

   task automatic test_sub_err_and_write();
      int lat, extra;
      logic err;
      logic [31:0] rd;
      logic [127:0] ra;
      resp_mode = 2; resp_delay = 2; resp_dat = 32'h1234_5678;
      wb_xfer(1'b0, 8'hA4, 4'hF, 32'h0, lat, err, rd, ra, extra);
      n_vec++;
      if (err !== 1'b1 || rd !== 32'h0 || lat !== 4 || extra !== 0) begin
         n_fail++;
         $display("FAIL sub_err_read: got err=%b data=%h lat=%0d extra=%0d want 1/0/4/0", err, rd, lat, extra);
      end
      resp_mode = 1; resp_delay = 1;
      wb_xfer(1'b1, 8'h84, 4'b1001, 32'h55AA_33CC, lat, err, rd, ra, extra);
      n_vec++;
      if (err !== 1'b0 || lat !== 3 || extra !== 0) begin
         n_fail++;
         $display("FAIL sub_write_ack: got err=%b lat=%0d extra=%0d want 0/3/0", err, lat, extra);
      end
      n_vec++;
      if (sub_adr_seen !== 7'h04 || sub_we_seen !== 1'b1 || sub_sel_seen !== 4'b1001
          || sub_wdat_seen !== 32'h55AA_33CC) begin
         n_fail++;
         $display("FAIL sub_write_fwd: got adr=%h we=%b sel=%b dat=%h want 04/1/1001/55aa33cc",
                  sub_adr_seen, sub_we_seen, sub_sel_seen, sub_wdat_seen);
      end
   endtask

   task automatic test_sub_timeout();
      int lat, extra;
      logic err;
      logic [31:0] rd;
      logic [127:0] ra;
      resp_mode = 0;
      wb_xfer(1'b1, 8'h88, 4'hF, 32'h0BAD_0BAD, lat, err, rd, ra, extra);
      n_vec++;
      if (err !== 1'b1 || lat !== 10 || extra !== 0) begin
         n_fail++;
         $display("FAIL timeout_err: got err=%b lat=%0d extra=%0d want 1/10/0", err, lat, extra);
      end
      n_vec++;
      if (sub_last !== 8 || sub_cyc_o !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_burst: got burst=%0d cyc=%b want 8/0", sub_last, sub_cyc_o);
      end
      wb_xfer(1'b0, 8'h08, 4'hF, 32'h0, lat, err, rd, ra, extra);
      n_vec++;
      if (rd !== 32'h0022_0044 || lat !== 2 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL after_timeout_read: got %h lat=%0d err=%b want 00220044/2/0", rd, lat, err);
      end
   endtask

   task automatic test_reset_mid_sub();
      int lat, extra, stray;
      logic err;
      logic [31:0] rd;
      logic [127:0] ra;
      resp_mode = 0;
      @(negedge clk_i);
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 6'h24; wb_sel_i = 4'hF;
      repeat (2) @(negedge clk_i);
      n_vec++;
      if (sub_cyc_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_sub_active: got cyc=%b want 1", sub_cyc_o);
      end
      rst_i = 1'b1;
      #1;
      n_vec++;
      if ({sub_cyc_o, sub_stb_o, wb_ack_o, wb_err_o} !== 4'b0) begin
         n_fail++;
         $display("FAIL mid_sub_reset: got cyc/stb/ack/err=%b want 0000", {sub_cyc_o, sub_stb_o, wb_ack_o, wb_err_o});
      end
      @(negedge clk_i);
      rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      force_ack = 1'b1;
      stray = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         if (i == 1) force_ack = 1'b0;
         if (wb_ack_o || wb_err_o || sub_cyc_o) stray++;
      end
      n_vec++;
      if (stray !== 0) begin
         n_fail++;
         $display("FAIL late_ack_ignored: got %0d active cycles want 0", stray);
      end
      n_vec++;
      if (regs_o !== {4{RV}}) begin
         n_fail++;
         $display("FAIL regs_after_reset: got %h want %h", regs_o, {4{RV}});
      end
      wb_xfer(1'b0, 8'h04, 4'hF, 32'h0, lat, err, rd, ra, extra);
      n_vec++;
      if (rd !== RV || lat !== 2 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_read: got %h lat=%0d err=%b want %h/2/0", rd, lat, err, RV);
      end
   endtask

   initial begin
      rst_i = 1'b1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
      repeat (3) @(negedge clk_i);
      test_reset();
      test_reg_rw();
      test_out_of_range();
      test_sub_read();
      test_sub_err_and_write();
      test_sub_timeout();
      test_reset_mid_sub();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
